// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state type, default widths and sizing helper for the MAC accumulate stage
// Contents:
//   state_t      ACC (collecting products) / HOLD (result presented)
//   *_DEF        default PROD_W / ACC_W / NTERMS
//   CNT_W        width of the per-group product count
//   min_acc_w()  smallest ACC_W that can never overflow for a given group size
package mac_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 10;
    localparam int NTERMS_DEF = 4;
    localparam int CNT_W      = 8;

    // nterms * (2^prod_w - 1) < 2^(prod_w + clog2(nterms))
    function automatic int min_acc_w(input int prod_w, input int nterms);
        return prod_w + $clog2(nterms);
    endfunction

endpackage

// File: rtl/mac_acc_add.sv
// rtl/mac_acc_add.sv - combinational accumulator adder with carry-out and optional saturation
// Macro: MAC_ACCUM_SAT_EN (defined: clamp to all-ones on carry; undefined: wrap)
// Ports:
//   acc    in  ACC_W   running accumulator
//   term   in  PROD_W  unsigned product, zero-extended before the add
//   sum    out ACC_W   wrapped or saturated result
//   carry  out 1       carry out of bit ACC_W-1
module mac_acc_add #(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] term,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, term};
        carry = full[ACC_W];
`ifdef MAC_ACCUM_SAT_EN
        // Once clamped, any nonzero term carries again, so the value sticks at max.
        sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accum_stage.sv
// rtl/mac_accum_stage.sv - sums groups of NTERMS products and presents each sum over valid/ready
// Macro: MAC_ACCUM_SAT_EN (saturating accumulator; default build wraps)
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   prod_valid/data/ready    product input handshake
//   flush                    close a non-empty group early (ignored while a result is held)
//   sum_valid/data/count/ovf result output, held stable until sum_ready
//   sum_ready                downstream accepts result
module mac_accum_stage
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int NTERMS = NTERMS_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    input  logic              flush,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_ovf,
    input  logic              sum_ready
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             hs;
    logic             flush_eff;
    logic             last_term;
    logic             close;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    mac_acc_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_add (
        .acc  (acc),
        .term (prod_data),
        .sum  (add_sum),
        .carry(add_carry)
    );

    // acc/cnt/ovf are already zero in HOLD, so a product taken in the cycle
    // the result is consumed simply starts the next group from zero.
    assign prod_ready = (state == ACC) || sum_ready;
    assign sum_valid  = (state == HOLD);

    always_comb begin
        hs        = prod_valid && prod_ready;
        flush_eff = flush && (state == ACC);
        last_term = (cnt == CNT_W'(NTERMS - 1));
        close     = (hs && (last_term || flush_eff)) ||
                    (!hs && flush_eff && (cnt != '0));
        res_data  = hs ? add_sum : acc;
        res_count = hs ? cnt + CNT_W'(1) : cnt;
        res_ovf   = ovf || (hs && add_carry);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_data  <= '0;
            sum_count <= '0;
            sum_ovf   <= 1'b0;
        end else if (close) begin
            state     <= HOLD;
            sum_data  <= res_data;
            sum_count <= res_count;
            sum_ovf   <= res_ovf;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (hs) begin
                acc <= add_sum;
                cnt <= res_count;
                ovf <= res_ovf;
            end
            if ((state == HOLD) && sum_ready) begin
                state <= ACC;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_stage.sv
// tb/tb_mac_accum_stage.sv - self-checking bench for mac_accum_stage (ACC_W=10 and ACC_W=9 instances)
module tb_mac_accum_stage;

    localparam int NT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prod_valid;
    logic [7:0] prod_data;
    logic       flush;
    logic       sum_ready;

    logic       prod_ready, sum_valid, sum_ovf;
    logic [9:0] sum_data;
    logic [7:0] sum_count;

    logic       prod_ready9, sum_valid9, sum_ovf9;
    logic [8:0] sum_data9;
    logic [7:0] sum_count9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accum_stage #(.PROD_W(8), .NTERMS(NT), .ACC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(prod_ready), .flush(flush), .sum_valid(sum_valid),
        .sum_data(sum_data), .sum_count(sum_count), .sum_ovf(sum_ovf),
        .sum_ready(sum_ready)
    );

    mac_accum_stage #(.PROD_W(8), .NTERMS(NT), .ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(prod_ready9), .flush(flush), .sum_valid(sum_valid9),
        .sum_data(sum_data9), .sum_count(sum_count9), .sum_ovf(sum_ovf9),
        .sum_ready(sum_ready)
    );

    // Reference: what a W-bit accumulator reports for an exact group total.
    function automatic int ref_sum(input longint total, input int w);
        longint lim = longint'(1) << w;
`ifdef MAC_ACCUM_SAT_EN
        return (total >= lim) ? int'(lim - 1) : int'(total);
`else
        return int'(total % lim);
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        prod_data  = 8'd0;
        flush      = 1'b0;
    endtask

    task automatic send(input int d);
        prod_valid = 1'b1;
        prod_data  = 8'(d);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sum_ready = 1'b1;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got %0b want 0", sum_valid); end
        checks++; if (sum_data !== 10'd0) begin errors++; $display("FAIL reset_sum_data got %0d want 0", sum_data); end
        checks++; if (sum_count !== 8'd0) begin errors++; $display("FAIL reset_sum_count got %0d want 0", sum_count); end
        checks++; if (sum_ovf !== 1'b0) begin errors++; $display("FAIL reset_sum_ovf got %0b want 0", sum_ovf); end
        sum_ready = 1'b0;
        #1;
        checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL reset_prod_ready got %0b want 1", prod_ready); end
        sum_ready = 1'b1;
    endtask

    task automatic test_basic();
        send(3); send(5); send(7);
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", sum_valid); end
        send(9);
        checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", sum_valid); end
        checks++; if (sum_data !== 10'd24) begin errors++; $display("FAIL basic_data got %0d want 24", sum_data); end
        checks++; if (sum_count !== 8'd4) begin errors++; $display("FAIL basic_count got %0d want 4", sum_count); end
        checks++; if (sum_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", sum_ovf); end
        cyc();
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %0b want 0", sum_valid); end
    endtask

    task automatic test_overflow();
        int e9;
        for (int i = 0; i < 4; i++) send(225);
        e9 = ref_sum(900, 9);
        checks++; if (sum_data !== 10'd900) begin errors++; $display("FAIL ovf10_data got %0d want 900", sum_data); end
        checks++; if (sum_ovf !== 1'b0) begin errors++; $display("FAIL ovf10_flag got %0b want 0", sum_ovf); end
        checks++; if (sum_valid9 !== 1'b1) begin errors++; $display("FAIL ovf9_valid got %0b want 1", sum_valid9); end
        checks++; if (int'(sum_data9) !== e9) begin errors++; $display("FAIL ovf9_data got %0d want %0d", sum_data9, e9); end
        checks++; if (sum_ovf9 !== 1'b1) begin errors++; $display("FAIL ovf9_flag got %0b want 1", sum_ovf9); end
        cyc();
    endtask

    task automatic test_flush();
        send(10); send(20);
        flush = 1'b1;
        send(30);
        checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %0b want 1", sum_valid); end
        checks++; if (sum_data !== 10'd60) begin errors++; $display("FAIL flush_data got %0d want 60", sum_data); end
        checks++; if (sum_count !== 8'd3) begin errors++; $display("FAIL flush_count got %0d want 3", sum_count); end
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b want 0", sum_valid); end
        cyc();
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL flush_empty2 got %0b want 0", sum_valid); end
    endtask

    task automatic test_backpressure();
        sum_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        prod_valid = 1'b1;
        prod_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL bp_prod_ready cyc %0d got %0b want 0", i, prod_ready); end
            checks++; if (sum_valid !== 1'b1 || sum_data !== 10'd10) begin errors++; $display("FAIL bp_hold cyc %0d got %0b/%0d want 1/10", i, sum_valid, sum_data); end
            cyc();
        end
        sum_ready = 1'b1;
        prod_data = 8'd6;
        #1;
        checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", prod_ready); end
        cyc();
        idle();
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %0b want 0", sum_valid); end
        checks++; if (dut.acc !== 10'd6 || dut.cnt !== 8'd1) begin errors++; $display("FAIL bp_next_group got acc=%0d cnt=%0d want 6/1", dut.acc, dut.cnt); end
        send(1); send(1); send(1);
        checks++; if (sum_data !== 10'd9 || sum_count !== 8'd4) begin errors++; $display("FAIL bp_group got %0d/%0d want 9/4", sum_data, sum_count); end
        cyc();
    endtask

    task automatic test_reset_mid();
        send(7); send(8);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++; if (sum_valid !== 1'b0 || sum_data !== 10'd0 || sum_count !== 8'd0 || sum_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got %0b/%0d/%0d/%0b want 0/0/0/0", sum_valid, sum_data, sum_count, sum_ovf); end
        checks++; if (prod_ready !== 1'b1 || dut.acc !== 10'd0) begin errors++; $display("FAIL rstmid_state got ready=%0b acc=%0d want 1/0", prod_ready, dut.acc); end
        for (int i = 0; i < 4; i++) send(1);
        checks++; if (sum_valid !== 1'b1 || sum_data !== 10'd4 || sum_count !== 8'd4) begin errors++; $display("FAIL rstmid_fresh got %0b/%0d/%0d want 1/4/4", sum_valid, sum_data, sum_count); end
        // reset while a result is being held
        sum_ready = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++; if (sum_valid !== 1'b0 || sum_data !== 10'd0 || sum_count !== 8'd0) begin errors++; $display("FAIL rsthold_outputs got %0b/%0d/%0d want 0/0/0", sum_valid, sum_data, sum_count); end
        sum_ready = 1'b1;
    endtask

    task automatic test_random();
        bit     pending = 1'b0;
        int     exp_d10 = 0, exp_d9 = 0, exp_cnt = 0;
        bit     exp_ovf9 = 1'b0;
        longint total = 0;
        int     tcnt = 0, accepted = 0, cycles = 0;
        bit     pv, sr, fl, take;
        int     d;
        while (accepted < 1000 && cycles < 20000) begin
            pv = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0);
            d  = $urandom_range(0, 225);
            prod_valid = pv; sum_ready = sr; flush = fl; prod_data = 8'(d);
            #1;
            checks++; if (sum_valid !== pending) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cycles, sum_valid, pending); end
            checks++; if (prod_ready !== (!pending || sr)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cycles, prod_ready, !pending || sr); end
            take = pv && (!pending || sr);
            if (pending && sr) begin
                checks++;
                if (int'(sum_data) !== exp_d10 || int'(sum_count) !== exp_cnt || sum_ovf !== 1'b0 ||
                    int'(sum_data9) !== exp_d9 || sum_ovf9 !== exp_ovf9) begin
                    errors++;
                    $display("FAIL rnd_sum cyc %0d got %0d/%0d/%0b w9 %0d/%0b want %0d/%0d/0 w9 %0d/%0b",
                             cycles, sum_data, sum_count, sum_ovf, sum_data9, sum_ovf9,
                             exp_d10, exp_cnt, exp_d9, exp_ovf9);
                end
            end
            if (take) begin
                total += d;
                tcnt++;
                accepted++;
            end
            // flush only counts when no result was waiting at the start of the cycle
            if ((take && tcnt == NT) || (fl && !pending && tcnt >= 1)) begin
                exp_d10  = ref_sum(total, 10);
                exp_d9   = ref_sum(total, 9);
                exp_ovf9 = (total > 511);
                exp_cnt  = tcnt;
                pending  = 1'b1;
                total    = 0;
                tcnt     = 0;
            end else if (pending && sr) begin
                pending = 1'b0;
            end
            cyc();
            cycles++;
        end
        idle();
        sum_ready = 1'b1;
        checks++; if (accepted < 1000) begin errors++; $display("FAIL rnd_timeout got %0d products want 1000", accepted); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
